// File: rtl/fft8_seq_if.sv
// fft8_seq_if -- control/handshake bundle for the 8-point FFT sequencer.
//
// Signals:
//   start     : request one 8-point transform (read by the sequencer)
//   bf_ready  : butterfly unit accepts the current issue
//   inverse   : conjugate-twiddle select, only with FFT8_SEQ_INVERSE_EN
//   bf_valid  : addr_a/addr_b/tw_index describe a valid butterfly
//   addr_a    : upper operand address
//   addr_b    : lower operand address
//   tw_index  : twiddle ROM index k for W8^k
//   stage     : current radix-2 stage, 0..2
//   busy      : transform in progress
//   done      : single-cycle completion pulse
//
// Modports: master = the sequencer, slave = the environment driving it.
// Optional feature macro: FFT8_SEQ_INVERSE_EN.
interface fft8_seq_if;
  logic       start;
  logic       bf_ready;
  logic       bf_valid;
  logic [2:0] addr_a;
  logic [2:0] addr_b;
  logic [2:0] tw_index;
  logic [1:0] stage;
  logic       busy;
  logic       done;
`ifdef FFT8_SEQ_INVERSE_EN
  logic       inverse;
`endif

  modport master (
`ifdef FFT8_SEQ_INVERSE_EN
    input  inverse,
`endif
    input  start, bf_ready,
    output bf_valid, addr_a, addr_b, tw_index, stage, busy, done
  );

  modport slave (
`ifdef FFT8_SEQ_INVERSE_EN
    output inverse,
`endif
    output start, bf_ready,
    input  bf_valid, addr_a, addr_b, tw_index, stage, busy, done
  );
endinterface

// File: rtl/fft8_if.sv
// The FFT8 sequencer interface is defined in rtl/fft8_seq_if.sv.

// File: rtl/fft8_seq.sv
// fft8_seq -- address/twiddle sequencer for a radix-2 8-point FFT.
//
// Walks 3 stages x 4 butterflies, issuing (addr_a, addr_b, tw_index) on a
// valid/ready handshake, and waits BF_LAT idle cycles between stages so the
// butterfly pipeline drains before the next stage reads its results.
//
// Ports:
//   clk : single clock, rising edge
//   rst : synchronous, active-high reset
//   bus : fft8_seq_if.master (start, bf_ready, [inverse] in;
//         bf_valid, addr_a, addr_b, tw_index, stage, busy, done out)
//
// Parameter BF_LAT : butterfly pipeline latency / drain length, 1..7.
// Optional macro FFT8_SEQ_INVERSE_EN : adds the inverse input; when latched
// high at start, tw_index becomes the conjugate twiddle (8-k)&7.
module fft8_seq #(
  parameter int BF_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  fft8_seq_if.master bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  localparam logic [2:0] DRAIN_LAST = 3'(BF_LAT - 1);

  logic [1:0] state;
  logic [1:0] stage_q;
  logic [1:0] j_q;
  logic [2:0] drain_cnt;
  logic       bf_valid_q;
  logic       busy_q;
  logic       done_q;
  logic [2:0] addr_a_q;
  logic [2:0] addr_b_q;
  logic [2:0] tw_q;

  logic [1:0] nxt_stage;
  logic [1:0] nxt_j;
  logic [8:0] nxt_abk;
  logic [2:0] nxt_tw;

  // Returns {addr_a, addr_b, k} for butterfly j of stage s.
  function automatic logic [8:0] bfly_of(input logic [1:0] s, input logic [1:0] j);
    logic [2:0] half;
    logic [2:0] pos;
    logic [2:0] grp;
    logic [2:0] a;
    half = 3'd1 << s;
    pos  = {1'b0, j} & (half - 3'd1);
    grp  = {1'b0, j} >> s;
    a    = ((grp * half) << 1) + pos;
    return {a, a + half, pos * (3'd4 >> s)};
  endfunction

  // Coordinates of the butterfly that will be presented after this edge,
  // used whenever the registered outputs are reloaded.
  always_comb begin
    nxt_stage = stage_q;
    nxt_j     = j_q;
    case (state)
      S_IDLE: begin
        nxt_stage = 2'd0;
        nxt_j     = 2'd0;
      end
      S_ISSUE: nxt_j = j_q + 2'd1;
      S_DRAIN: begin
        nxt_stage = stage_q + 2'd1;
        nxt_j     = 2'd0;
      end
      default: ;
    endcase
  end

  assign nxt_abk = bfly_of(nxt_stage, nxt_j);

`ifdef FFT8_SEQ_INVERSE_EN
  logic inv_q;
  logic inv_sel;

  // In IDLE the mode being latched this edge applies to the first issue.
  assign inv_sel = (state == S_IDLE) ? bus.inverse : inv_q;
  // (8-k)&7 is simply -k modulo 8.
  assign nxt_tw  = inv_sel ? (3'd0 - nxt_abk[2:0]) : nxt_abk[2:0];
`else
  assign nxt_tw  = nxt_abk[2:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      stage_q    <= 2'd0;
      j_q        <= 2'd0;
      drain_cnt  <= 3'd0;
      bf_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      addr_a_q   <= 3'd0;
      addr_b_q   <= 3'd0;
      tw_q       <= 3'd0;
`ifdef FFT8_SEQ_INVERSE_EN
      inv_q      <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state      <= S_ISSUE;
            stage_q    <= nxt_stage;
            j_q        <= nxt_j;
            bf_valid_q <= 1'b1;
            busy_q     <= 1'b1;
            addr_a_q   <= nxt_abk[8:6];
            addr_b_q   <= nxt_abk[5:3];
            tw_q       <= nxt_tw;
`ifdef FFT8_SEQ_INVERSE_EN
            inv_q      <= bus.inverse;
`endif
          end
        end
        S_ISSUE: begin
          // bf_valid is always high here, so acceptance is just bf_ready.
          if (bus.bf_ready) begin
            if (j_q == 2'd3) begin
              state      <= S_DRAIN;
              bf_valid_q <= 1'b0;
              drain_cnt  <= 3'd0;
            end else begin
              j_q      <= nxt_j;
              addr_a_q <= nxt_abk[8:6];
              addr_b_q <= nxt_abk[5:3];
              tw_q     <= nxt_tw;
            end
          end
        end
        S_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            if (stage_q == 2'd2) begin
              state  <= S_FIN;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              state      <= S_ISSUE;
              stage_q    <= nxt_stage;
              j_q        <= nxt_j;
              bf_valid_q <= 1'b1;
              addr_a_q   <= nxt_abk[8:6];
              addr_b_q   <= nxt_abk[5:3];
              tw_q       <= nxt_tw;
            end
          end else begin
            drain_cnt <= drain_cnt + 3'd1;
          end
        end
        default: begin
          // FIN: one-cycle done pulse; start here is deliberately dropped.
          state  <= S_IDLE;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.bf_valid = bf_valid_q;
  assign bus.addr_a   = addr_a_q;
  assign bus.addr_b   = addr_b_q;
  assign bus.tw_index = tw_q;
  assign bus.stage    = stage_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_fft8_seq.sv
// tb_fft8_seq -- self-checking bench for fft8_seq (BF_LAT = 2).
// Issued butterflies are checked against a scoreboard queue loaded from the
// reference issue table whenever a transform is started.
`timescale 1ns/1ps
module tb_fft8_seq;
  localparam int BF_LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  fft8_seq_if bus ();

  fft8_seq #(.BF_LAT(BF_LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference issue order, {a,b,k} as three octal digits.
  logic [8:0] tbl [0:11] = '{9'o010, 9'o230, 9'o450, 9'o670,
                             9'o020, 9'o132, 9'o460, 9'o572,
                             9'o040, 9'o151, 9'o262, 9'o373};

  logic [10:0] exp_q [$];
  logic [10:0] mon_exp;
  logic [10:0] mon_got;

  // Results of the last run_xform call.
  int          r_done_cyc, r_done_cnt, r_vcnt, r_bfirst, r_blast, r_bcnt;
  int          r_stall_bad, r_next_valid;
  logic [63:0] r_vmask;

  task automatic push_seq(input bit inv);
    logic [8:0] t;
    logic [2:0] k;
    for (int i = 0; i < 12; i++) begin
      t = tbl[i];
      k = t[2:0];
      if (inv) k = 3'((4'd8 - {1'b0, k}) & 4'd7);
      exp_q.push_back({2'(i / 4), t[8:3], k});
    end
  endtask

  // Scoreboard: every accepted issue must match the next expected entry.
  always @(negedge clk) begin
    if (!rst && bus.bf_valid === 1'b1 && bus.bf_ready === 1'b1) begin
      mon_got = {bus.stage, bus.addr_a, bus.addr_b, bus.tw_index};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_issue got=%h required=none", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL sb_issue got(s,a,b,k)=%0d,%0d,%0d,%0d required=%0d,%0d,%0d,%0d",
                   mon_got[10:9], mon_got[8:6], mon_got[5:3], mon_got[2:0],
                   mon_exp[10:9], mon_exp[8:6], mon_exp[5:3], mon_exp[2:0]);
        end
      end
    end
  end

  // Starts one transform and observes it cycle by cycle (r = cycles after
  // the cycle in which start was driven). Optionally stalls issue number
  // stall_at for stall_len cycles and/or keeps start high.
  task automatic run_xform(input int stall_at, input int stall_len, input bit hold,
                           input int n_push, input bit inv);
    int s0, r, hs, rem;
    bit snapped;
    logic [10:0] snap, cur;
    r_done_cyc = -1; r_done_cnt = 0; r_vcnt = 0; r_vmask = '0;
    r_bfirst = -1; r_blast = -1; r_bcnt = 0; r_stall_bad = 0; r_next_valid = -1;
    hs = 0; rem = stall_len; snapped = 1'b0; snap = '0;
    @(posedge clk); #1;
    bus.bf_ready = 1'b1;
    bus.start    = 1'b1;
`ifdef FFT8_SEQ_INVERSE_EN
    bus.inverse  = inv;
`endif
    for (int n = 0; n < n_push; n++) push_seq(inv);
    s0 = cyc;
    r  = 0;
    while (r < 150) begin
      @(posedge clk); #1;
      r = cyc - s0;
      if (!hold) bus.start = 1'b0;
`ifdef FFT8_SEQ_INVERSE_EN
      bus.inverse = ~inv;
`endif
      cur = {bus.stage, bus.addr_a, bus.addr_b, bus.tw_index};
      if (r_done_cyc >= 0) begin
        if (bus.done) r_done_cnt++;
        if (bus.bf_valid) r_next_valid = r;
        if (bus.bf_valid || r >= r_done_cyc + (hold ? 4 : 1)) break;
      end else begin
        if (bus.busy) begin
          r_bcnt++;
          if (r_bfirst < 0) r_bfirst = r;
          r_blast = r;
        end
        if (bus.done) begin
          r_done_cyc = r;
          r_done_cnt++;
        end
        if (bus.bf_valid) begin
          r_vcnt++;
          if (r < 64) r_vmask[r] = 1'b1;
          if (hs == stall_at) begin
            if (!snapped) begin
              snap = cur;
              snapped = 1'b1;
            end else if (cur !== snap) begin
              r_stall_bad++;
            end
          end
          if (hs == stall_at && rem > 0) begin
            bus.bf_ready = 1'b0;
            rem--;
          end else begin
            bus.bf_ready = 1'b1;
            hs++;
          end
        end else begin
          bus.bf_ready = 1'b1;
        end
      end
    end
    bus.start    = 1'b0;
    bus.bf_ready = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.bf_valid !== 1'b0) begin errors++; $display("FAIL rst_bf_valid got=%b required=0", bus.bf_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b required=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b required=0", bus.done); end
    checks++; if (bus.addr_a !== 3'd0) begin errors++; $display("FAIL rst_addr_a got=%0d required=0", bus.addr_a); end
    checks++; if (bus.addr_b !== 3'd0) begin errors++; $display("FAIL rst_addr_b got=%0d required=0", bus.addr_b); end
    checks++; if (bus.tw_index !== 3'd0) begin errors++; $display("FAIL rst_tw_index got=%0d required=0", bus.tw_index); end
    checks++; if (bus.stage !== 2'd0) begin errors++; $display("FAIL rst_stage got=%0d required=0", bus.stage); end
    rst = 1'b0;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.bf_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_without_start busy=%b bf_valid=%b required=0,0", bus.busy, bus.bf_valid);
    end
  endtask

  task automatic test_sequence();
    logic [63:0] exp_mask;
    exp_mask = '0;
    for (int t = 1; t <= 4; t++) begin
      exp_mask[t] = 1'b1;
      exp_mask[t + 4 + BF_LAT] = 1'b1;
      exp_mask[t + 8 + 2 * BF_LAT] = 1'b1;
    end
    run_xform(-1, 0, 1'b0, 1, 1'b0);
    checks++; if (r_done_cyc != 13 + 3 * BF_LAT) begin errors++; $display("FAIL seq_done_cycle got=%0d required=%0d", r_done_cyc, 13 + 3 * BF_LAT); end
    checks++; if (r_done_cnt != 1) begin errors++; $display("FAIL seq_done_pulses got=%0d required=1", r_done_cnt); end
    checks++; if (r_vcnt != 12) begin errors++; $display("FAIL seq_valid_count got=%0d required=12", r_vcnt); end
    checks++; if (r_vmask !== exp_mask) begin errors++; $display("FAIL seq_valid_cycles got=%h required=%h", r_vmask, exp_mask); end
    checks++; if (r_bfirst != 1) begin errors++; $display("FAIL seq_busy_first got=%0d required=1", r_bfirst); end
    checks++; if (r_blast != 12 + 3 * BF_LAT) begin errors++; $display("FAIL seq_busy_last got=%0d required=%0d", r_blast, 12 + 3 * BF_LAT); end
    checks++; if (r_bcnt != 12 + 3 * BF_LAT) begin errors++; $display("FAIL seq_busy_count got=%0d required=%0d", r_bcnt, 12 + 3 * BF_LAT); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL seq_issues_left got=%0d required=0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_stall();
    run_xform(5, 3, 1'b0, 1, 1'b0);
    checks++; if (r_done_cyc != 16 + 3 * BF_LAT) begin errors++; $display("FAIL stall_done_cycle got=%0d required=%0d", r_done_cyc, 16 + 3 * BF_LAT); end
    checks++; if (r_stall_bad != 0) begin errors++; $display("FAIL stall_hold_changes got=%0d required=0", r_stall_bad); end
    checks++; if (r_vcnt != 15) begin errors++; $display("FAIL stall_valid_count got=%0d required=15", r_vcnt); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stall_issues_left got=%0d required=0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    bit found, saw_done, saw_valid;
    found = 1'b0; saw_done = 1'b0; saw_valid = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1;
    push_seq(1'b0);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.stage === 2'd1 && bus.bf_valid === 1'b0 && bus.busy === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    checks++; if (!found) begin errors++; $display("FAIL rmid_reach_drain got=0 required=1"); end
    rst = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.start = 1'b0;
    exp_q.delete();
    checks++;
    if ({bus.bf_valid, bus.busy, bus.done, bus.addr_a, bus.addr_b, bus.tw_index, bus.stage} !== 14'd0) begin
      errors++;
      $display("FAIL rmid_outputs_zero got v=%b busy=%b done=%b a=%0d b=%0d k=%0d s=%0d required all 0",
               bus.bf_valid, bus.busy, bus.done, bus.addr_a, bus.addr_b, bus.tw_index, bus.stage);
    end
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (bus.done) saw_done = 1'b1;
      if (bus.bf_valid) saw_valid = 1'b1;
    end
    checks++; if (saw_done) begin errors++; $display("FAIL rmid_no_done got=1 required=0"); end
    checks++; if (saw_valid) begin errors++; $display("FAIL rmid_stays_idle got=1 required=0"); end
    run_xform(-1, 0, 1'b0, 1, 1'b0);
    checks++; if (r_done_cyc != 13 + 3 * BF_LAT) begin errors++; $display("FAIL rmid_rerun_done got=%0d required=%0d", r_done_cyc, 13 + 3 * BF_LAT); end
    checks++; if (r_vcnt != 12) begin errors++; $display("FAIL rmid_rerun_valid got=%0d required=12", r_vcnt); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rmid_issues_left got=%0d required=0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    bit found;
    found = 1'b0;
    run_xform(-1, 0, 1'b1, 2, 1'b0);
    checks++; if (r_done_cyc != 13 + 3 * BF_LAT) begin errors++; $display("FAIL b2b_done_cycle got=%0d required=%0d", r_done_cyc, 13 + 3 * BF_LAT); end
    checks++; if (r_next_valid != r_done_cyc + 2 || r_done_cyc < 0) begin errors++; $display("FAIL b2b_restart_cycle got=%0d required=%0d", r_next_valid, r_done_cyc + 2); end
    checks++; if (r_done_cnt != 1) begin errors++; $display("FAIL b2b_done_pulses got=%0d required=1", r_done_cnt); end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        found = 1'b1;
        break;
      end
    end
    checks++; if (!found) begin errors++; $display("FAIL b2b_second_done got=0 required=1"); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_issues_left got=%0d required=0", exp_q.size()); end
    exp_q.delete();
  endtask

`ifdef FFT8_SEQ_INVERSE_EN
  task automatic test_inverse();
    run_xform(-1, 0, 1'b0, 1, 1'b1);
    checks++; if (r_done_cyc != 13 + 3 * BF_LAT) begin errors++; $display("FAIL inv_done_cycle got=%0d required=%0d", r_done_cyc, 13 + 3 * BF_LAT); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL inv_issues_left got=%0d required=0", exp_q.size()); end
    exp_q.delete();
    run_xform(-1, 0, 1'b0, 1, 1'b0);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL fwd_issues_left got=%0d required=0", exp_q.size()); end
    exp_q.delete();
  endtask
`endif

  initial begin
    rst = 1'b1;
    bus.start = 1'b1;
    bus.bf_ready = 1'b1;
`ifdef FFT8_SEQ_INVERSE_EN
    bus.inverse = 1'b0;
`endif
    test_reset();
    test_sequence();
    test_stall();
    test_reset_mid();
    test_back_to_back();
`ifdef FFT8_SEQ_INVERSE_EN
    test_inverse();
`endif
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule
